adc_capture_ctrl: RTL and testbench

Acquisition sequencer for the dual-channel 14-bit Zmod ADC datapath. It waits for converter init, arms on a software start, detects a trigger on channel 1 (immediate, rising or falling threshold crossing), and writes a programmable number of optionally decimated {ch2,ch1} sample pairs into an external simple-dual-port BRAM. It sits in the system clock domain between the ADC controller wrapper outputs and the capture buffer read by the processor.

---
 rtl/adc_capture_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_ctrl.sv
// Capture sequencer for the dual-channel Zmod ADC: arms on start, triggers on ch1,
// and streams optionally decimated {ch2,ch1} pairs into a simple-dual-port buffer.
module adc_capture_ctrl #(
    parameter int unsigned ZMOD_DATA_SIZE = 14,
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DECIM_WIDTH    = 16
) (
    input  logic                          i_sys_clock,
    input  logic                          i_reset,
    input  logic                          i_init_done,
    input  logic                          i_data_valid,
    input  logic [ZMOD_DATA_SIZE-1:0]     i_ch1_data,
    input  logic [ZMOD_DATA_SIZE-1:0]     i_ch2_data,
    input  logic                          i_start,
    input  logic                          i_abort,
    input  logic [1:0]                    i_trig_mode,
    input  logic [ZMOD_DATA_SIZE-1:0]     i_trig_level,
    input  logic [ADDR_WIDTH-1:0]         i_num_samples,
    input  logic [DECIM_WIDTH-1:0]        i_decim,
    output logic                          o_wr_en,
    output logic [ADDR_WIDTH-1:0]         o_wr_addr,
    output logic [2*ZMOD_DATA_SIZE-1:0]   o_wr_data,
    output logic                          o_armed,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic [1:0]                    mode_q, mode_d;
    logic [ZMOD_DATA_SIZE-1:0]     level_q, level_d;
    logic [ADDR_WIDTH-1:0]         nsamp_q, nsamp_d;
    logic [DECIM_WIDTH-1:0]        decim_q, decim_d;
    logic [DECIM_WIDTH-1:0]        decim_cnt_q, decim_cnt_d;
    logic [ADDR_WIDTH-1:0]         idx_q, idx_d;
    logic [ZMOD_DATA_SIZE-1:0]     prev_q, prev_d;
    logic                          prev_vld_q, prev_vld_d;
    logic                          wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]         wr_addr_q, wr_addr_d;
    logic [2*ZMOD_DATA_SIZE-1:0]   wr_data_q, wr_data_d;
    logic                          armed_q, armed_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          error_q, error_d;

    logic                          rise_hit, fall_hit, trig_hit;
    logic                          arm_req;

    // Edge detection needs one valid sample seen since arming before it may fire.
    always_comb begin
        rise_hit = prev_vld_q
                && ($signed(prev_q) < $signed(level_q))
                && ($signed(i_ch1_data) >= $signed(level_q));
        fall_hit = prev_vld_q
                && ($signed(prev_q) > $signed(level_q))
                && ($signed(i_ch1_data) <= $signed(level_q));
        case (mode_q)
            2'd1:    trig_hit = rise_hit;
            2'd2:    trig_hit = fall_hit;
            default: trig_hit = 1'b1;
        endcase
        arm_req = i_start && i_init_done;
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        level_d     = level_q;
        nsamp_d     = nsamp_q;
        decim_d     = decim_q;
        decim_cnt_d = decim_cnt_q;
        idx_d       = idx_q;
        prev_d      = prev_q;
        prev_vld_d  = prev_vld_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = done_q;
        error_d     = error_q;

        case (state_q)
            IDLE: begin
                if (arm_req) begin
                    state_d    = ARMED;
                    mode_d     = i_trig_mode;
                    level_d    = i_trig_level;
                    nsamp_d    = i_num_samples;
                    decim_d    = i_decim;
                    prev_vld_d = 1'b0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                end
            end

            ARMED: begin
                if (i_abort) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end else if (!i_init_done) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                end else if (i_data_valid) begin
                    prev_d     = i_ch1_data;
                    prev_vld_d = 1'b1;
                    if (trig_hit) begin
                        wr_en_d     = 1'b1;
                        wr_addr_d   = '0;
                        wr_data_d   = {i_ch2_data, i_ch1_data};
                        idx_d       = ADDR_WIDTH'(1);
                        decim_cnt_d = decim_q;
                        state_d     = (nsamp_q == '0) ? DONE : CAPTURE;
                    end
                end
            end

            CAPTURE: begin
                if (i_abort) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end else if (!i_init_done) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                end else if (i_data_valid) begin
                    if (decim_cnt_q == '0) begin
                        wr_en_d     = 1'b1;
                        wr_addr_d   = idx_q;
                        wr_data_d   = {i_ch2_data, i_ch1_data};
                        decim_cnt_d = decim_q;
                        idx_d       = idx_q + ADDR_WIDTH'(1);
                        if (idx_q == nsamp_q) begin
                            state_d = DONE;
                        end
                    end else begin
                        decim_cnt_d = decim_cnt_q - DECIM_WIDTH'(1);
                    end
                end
            end

            DONE: begin
                // done rises here, one cycle after the final write strobe
                if (i_abort) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end else if (arm_req) begin
                    state_d    = ARMED;
                    mode_d     = i_trig_mode;
                    level_d    = i_trig_level;
                    nsamp_d    = i_num_samples;
                    decim_d    = i_decim;
                    prev_vld_d = 1'b0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                end else begin
                    done_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        armed_d = (state_d == ARMED);
        busy_d  = (state_d == ARMED) || (state_d == CAPTURE);
    end

    always_ff @(posedge i_sys_clock) begin
        if (i_reset) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            level_q     <= '0;
            nsamp_q     <= '0;
            decim_q     <= '0;
            decim_cnt_q <= '0;
            idx_q       <= '0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            armed_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            level_q     <= level_d;
            nsamp_q     <= nsamp_d;
            decim_q     <= decim_d;
            decim_cnt_q <= decim_cnt_d;
            idx_q       <= idx_d;
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            armed_q     <= armed_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign o_wr_en   = wr_en_q;
    assign o_wr_addr = wr_addr_q;
    assign o_wr_data = wr_data_q;
    assign o_armed   = armed_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_error   = error_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl: directed sample streams push expected
// buffer writes; a negedge monitor pops and compares every o_wr_en strobe.
module tb_adc_capture_ctrl;

    localparam int ZW = 14;
    localparam int AW = 12;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              i_reset, i_init_done, i_data_valid, i_start, i_abort;
    logic [ZW-1:0]     i_ch1_data, i_ch2_data, i_trig_level;
    logic [1:0]        i_trig_mode;
    logic [AW-1:0]     i_num_samples;
    logic [DW-1:0]     i_decim;
    logic              o_wr_en, o_armed, o_busy, o_done, o_error;
    logic [AW-1:0]     o_wr_addr;
    logic [2*ZW-1:0]   o_wr_data;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_wr_cyc = -1;
    int done_rise_cyc = -1;
    logic done_prev = 1'b0;
    logic [AW+2*ZW-1:0] expq[$];

    always #5 clk = ~clk;

    adc_capture_ctrl #(
        .ZMOD_DATA_SIZE(ZW),
        .ADDR_WIDTH(AW),
        .DECIM_WIDTH(DW)
    ) dut (
        .i_sys_clock(clk),
        .i_reset(i_reset),
        .i_init_done(i_init_done),
        .i_data_valid(i_data_valid),
        .i_ch1_data(i_ch1_data),
        .i_ch2_data(i_ch2_data),
        .i_start(i_start),
        .i_abort(i_abort),
        .i_trig_mode(i_trig_mode),
        .i_trig_level(i_trig_level),
        .i_num_samples(i_num_samples),
        .i_decim(i_decim),
        .o_wr_en(o_wr_en),
        .o_wr_addr(o_wr_addr),
        .o_wr_data(o_wr_data),
        .o_armed(o_armed),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_error(o_error)
    );

    // Monitor: every write strobe must match the oldest expected entry.
    always @(negedge clk) begin
        logic [AW+2*ZW-1:0] e;
        cyc = cyc + 1;
        if (o_done === 1'b1 && done_prev !== 1'b1) done_rise_cyc = cyc;
        done_prev = o_done;
        if (o_wr_en === 1'b1) begin
            last_wr_cyc = cyc;
            n_cmp = n_cmp + 1;
            if (expq.size() == 0) begin
                n_bad = n_bad + 1;
                $display("FAIL wr_unexpected: got addr=%0d data=%h, expected no write", o_wr_addr, o_wr_data);
            end else begin
                e = expq.pop_front();
                if ({o_wr_addr, o_wr_data} !== e) begin
                    n_bad = n_bad + 1;
                    $display("FAIL wr_compare: got addr=%0d data=%h, expected addr=%0d data=%h",
                             o_wr_addr, o_wr_data, e[AW+2*ZW-1:2*ZW], e[2*ZW-1:0]);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_wr(input int addr, input int c1);
        logic [ZW-1:0] v;
        v = ZW'(c1);
        expq.push_back({AW'(addr), ~v, v});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int c1);
        i_data_valid = v;
        i_ch1_data   = ZW'(c1);
        i_ch2_data   = ~ZW'(c1);
        tick();
    endtask

    task automatic do_start(input int mode, input int level, input int nsamp, input int decim);
        i_trig_mode   = 2'(mode);
        i_trig_level  = ZW'(level);
        i_num_samples = AW'(nsamp);
        i_decim       = DW'(decim);
        i_data_valid  = 1'b0;
        i_start       = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1; i_init_done = 1'b0; i_data_valid = 1'b0; i_start = 1'b0; i_abort = 1'b0;
        i_ch1_data = '0; i_ch2_data = '0; i_trig_level = '0; i_trig_mode = '0;
        i_num_samples = '0; i_decim = '0;
        repeat (3) tick();
        i_reset = 1'b0;
        tick();
        check("reset_outputs", {o_wr_en, o_armed, o_busy, o_done, o_error, o_wr_addr, o_wr_data}, 64'd0);

        // start without init is ignored
        do_start(0, 0, 3, 0);
        for (int k = 0; k < 3; k++) drive(1'b1, k);
        check("start_no_init", {o_armed, o_busy, o_done, o_error}, 64'd0);

        // immediate trigger, 4 samples
        i_init_done = 1'b1;
        do_start(0, 0, 3, 0);
        check("imm_armed", {o_armed, o_busy, o_done}, 64'b110);
        for (int k = 0; k < 4; k++) expect_wr(k, k);
        for (int k = 0; k < 7; k++) drive(1'b1, k);
        check("imm_done", {o_done, o_busy, o_armed, o_error}, 64'b1000);
        check("imm_done_latency", 64'(done_rise_cyc - last_wr_cyc), 64'd1);

        // rising trigger at 100
        do_start(1, 100, 1, 0);
        check("rise_restart_clears_done", {o_armed, o_done}, 64'b10);
        for (int k = 90; k < 100; k++) drive(1'b1, k);
        check("rise_still_armed", {o_armed, o_busy}, 64'b11);
        expect_wr(0, 100);
        expect_wr(1, 101);
        for (int k = 100; k <= 120; k++) drive(1'b1, k);
        check("rise_done", {o_done, o_armed}, 64'b10);

        // falling trigger at -50, single sample
        do_start(2, -50, 0, 0);
        expect_wr(0, -50);
        for (int k = 0; k >= -60; k--) drive(1'b1, k);
        check("fall_done", {o_done, o_busy}, 64'b10);

        // signed wrap 8191 -> -8192 must not fire rising at 0; -5 -> 3 must
        do_start(1, 0, 0, 0);
        drive(1'b1, 8190);
        drive(1'b1, 8191);
        drive(1'b1, -8192);
        drive(1'b1, -8191);
        check("wrap_no_trigger", {o_armed, o_done}, 64'b10);
        expect_wr(0, 3);
        drive(1'b1, -5);
        drive(1'b1, 3);
        drive(1'b1, 4);
        drive(1'b1, 5);
        check("signed_rise_done", {o_done, o_armed}, 64'b10);

        // decimation by 3 with invalid gaps; config change after start must not matter
        do_start(0, 0, 2, 2);
        i_decim = '0;
        i_num_samples = AW'(9);
        expect_wr(0, 200);
        expect_wr(1, 203);
        expect_wr(2, 206);
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 200 + k);
            drive(1'b0, 777);
        end
        check("decim_done", {o_done, o_busy}, 64'b10);

        // abort mid-capture suppresses the pending write
        do_start(0, 0, 7, 0);
        expect_wr(0, 10);
        expect_wr(1, 11);
        drive(1'b1, 10);
        drive(1'b1, 11);
        i_abort = 1'b1;
        drive(1'b1, 12);
        i_abort = 1'b0;
        check("abort_idle", {o_armed, o_busy, o_done, o_error}, 64'd0);
        for (int k = 13; k < 17; k++) drive(1'b1, k);

        // reset mid-capture
        do_start(0, 0, 7, 0);
        expect_wr(0, 20);
        expect_wr(1, 21);
        drive(1'b1, 20);
        drive(1'b1, 21);
        i_reset = 1'b1;
        drive(1'b1, 22);
        i_reset = 1'b0;
        check("reset_midcap", {o_wr_en, o_armed, o_busy, o_done, o_error}, 64'd0);
        for (int k = 23; k < 26; k++) drive(1'b1, k);

        // init loss during capture
        do_start(0, 0, 7, 0);
        expect_wr(0, 30);
        expect_wr(1, 31);
        expect_wr(2, 32);
        drive(1'b1, 30);
        drive(1'b1, 31);
        drive(1'b1, 32);
        i_init_done = 1'b0;
        drive(1'b1, 33);
        check("initloss_flags", {o_done, o_error, o_busy, o_armed}, 64'b1100);
        drive(1'b1, 34);
        i_init_done = 1'b1;
        drive(1'b1, 35);
        drive(1'b1, 36);
        check("initloss_sticky", {o_done, o_error}, 64'b11);
        do_start(0, 0, 1, 0);
        check("restart_clears", {o_done, o_error, o_armed}, 64'b001);
        expect_wr(0, 50);
        expect_wr(1, 51);
        for (int k = 50; k < 54; k++) drive(1'b1, k);
        check("restart_done", {o_done, o_error}, 64'b10);

        // full buffer, no wrap
        do_start(0, 0, (1 << AW) - 1, 0);
        for (int k = 0; k < (1 << AW); k++) expect_wr(k, k);
        for (int k = 0; k < (1 << AW) + 4; k++) drive(1'b1, k);
        check("full_done", {o_done, o_busy}, 64'b10);
        check("full_done_latency", 64'(done_rise_cyc - last_wr_cyc), 64'd1);

        // abort in DONE returns to idle
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("abort_in_done", {o_done, o_busy, o_armed}, 64'd0);

        tick();
        check("queue_drained", 64'(expq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
